dsm_interp_feeder: RTL

//  Input stage of the 6th-order DSM chain. Accepts audio samples over a valid/ready handshake.

---
 rtl/dsm_pkg.sv | 18 +
 rtl/dsm_fs_strobe.sv | 48 ++++
 rtl/dsm_interp_feeder.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/dsm_pkg.sv
// dsm_pkg: shared types and default widths for the DSM input feeder.
//   dsm_state_e  - interpolator FSM state encoding
//   DSM_*        - default parameter values for dsm_interp_feeder
package dsm_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_STARVE = 2'd2
   } dsm_state_e;

   localparam int DSM_DIN_W    = 16;
   localparam int DSM_DOUT_W   = 36;
   localparam int DSM_FS_DIV   = 64;
   localparam int DSM_OSR_LOG2 = 6;
   localparam int DSM_SHIFT    = 12;

endpackage

// File: rtl/dsm_fs_strobe.sv
// dsm_fs_strobe: divides clk by FS_DIV to produce a registered one-cycle
// sample strobe for the DSM chain.
// Ports:
//   clk     in   system clock
//   rst_n   in   synchronous active-low reset
//   en      in   run enable; when low the divider is held at 0 and no strobe
//   fs_enb  out  high for the single cycle in which the divider sits at FS_DIV-1
module dsm_fs_strobe
   import dsm_pkg::*;
#(
   parameter int FS_DIV = DSM_FS_DIV
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   output logic fs_enb
);

   localparam int DIV_W = $clog2(FS_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FS_DIV - 1);

   logic [DIV_W-1:0] div_q, div_d;
   logic             fs_enb_q, fs_enb_d;

   // fs_enb is computed from the next divider value so the registered
   // strobe lines up with the cycle in which div_q == FS_DIV-1.
   always_comb begin
      div_d    = '0;
      fs_enb_d = 1'b0;
      if (en) begin
         div_d    = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
         fs_enb_d = (div_d == DIV_LAST);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         div_q    <= '0;
         fs_enb_q <= 1'b0;
      end else begin
         div_q    <= div_d;
         fs_enb_q <= fs_enb_d;
      end
   end

   assign fs_enb = fs_enb_q;

endmodule

// File: rtl/dsm_interp_feeder.sv
// dsm_interp_feeder: input stage of the 6th-order DSM chain. Takes audio
// samples over valid/ready, paces them at 2^OSR_LOG2 fs ticks per sample and
// ramps linearly between successive samples into the first integrator.
// Build option: DSM_LINEAR_INTERP_EN - when defined, linear interpolation;
// when undefined, zero-order hold (each sample is applied in one step).
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   en              run enable for strobe and interpolator
//   s_valid/s_ready/s_data  sample handshake (one-deep pending slot)
//   fs_enb          one-clk sample strobe to the integrator chain
//   xout            interpolated sample, scaled by 2^SHIFT
//   underrun        sticky: a segment ended with no sample waiting
//   clr_underrun    clears underrun (a same-cycle set wins)
//
// state  | meaning
// IDLE   | nothing received since reset, acc = 0
// RUN    | stepping acc from held towards tgt, one step per tick
// STARVE | segment ended with no source, holding at last target
module dsm_interp_feeder
   import dsm_pkg::*;
#(
   parameter int DIN_W    = DSM_DIN_W,
   parameter int DOUT_W   = DSM_DOUT_W,
   parameter int FS_DIV   = DSM_FS_DIV,
   parameter int OSR_LOG2 = DSM_OSR_LOG2,
   parameter int SHIFT    = DSM_SHIFT
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     en,
   input  logic                     s_valid,
   output logic                     s_ready,
   input  logic signed [DIN_W-1:0]  s_data,
   output logic                     fs_enb,
   output logic signed [DOUT_W-1:0] xout,
   output logic                     underrun,
   input  logic                     clr_underrun
);

   localparam int ACC_W = DIN_W + OSR_LOG2;
   localparam logic [OSR_LOG2-1:0] PH_LAST = {OSR_LOG2{1'b1}};

   dsm_state_e               state_q, state_d;
   logic signed [DIN_W-1:0]  pend_q, pend_d;
   logic                     pend_vld_q, pend_vld_d;
   logic signed [DIN_W-1:0]  tgt_q, tgt_d;
   logic signed [DIN_W-1:0]  held_q, held_d;
   logic signed [DIN_W:0]    diff_q, diff_d;
   logic signed [ACC_W-1:0]  acc_q, acc_d;
   logic [OSR_LOG2-1:0]      phase_q, phase_d;
   logic                     underrun_q, underrun_d;
   logic signed [DOUT_W-1:0] xout_q, xout_d;

   logic                     tick, accept, src_avail, seg_start, set_ur;
   logic signed [DIN_W-1:0]  src;
   logic signed [ACC_W:0]    acc_sum;
   logic signed [DOUT_W-1:0] acc_ext;

   dsm_fs_strobe #(.FS_DIV(FS_DIV)) u_strobe (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (en),
      .fs_enb (fs_enb)
   );

   assign tick      = fs_enb & en;
   assign accept    = s_valid & ~pend_vld_q;
   // A sample arriving in the same cycle a segment starts is used directly.
   assign src_avail = pend_vld_q | accept;
   assign src       = pend_vld_q ? pend_q : s_data;
   // acc always lies between the held and target values (scaled), so the
   // extra sum bit never carries information and is simply dropped.
   assign acc_sum   = (ACC_W+1)'(acc_q) + (ACC_W+1)'(diff_q);
   assign acc_ext   = DOUT_W'(acc_q);

   always_comb begin
      state_d    = state_q;
      pend_d     = pend_q;
      pend_vld_d = pend_vld_q;
      tgt_d      = tgt_q;
      held_d     = held_q;
      diff_d     = diff_q;
      acc_d      = acc_q;
      phase_d    = phase_q;
      seg_start  = 1'b0;
      set_ur     = 1'b0;

      if (tick) begin
         case (state_q)
            ST_IDLE, ST_STARVE: begin
               if (src_avail) begin
                  seg_start = 1'b1;
                  state_d   = ST_RUN;
               end
            end
            ST_RUN: begin
               acc_d   = ACC_W'(acc_sum);
               phase_d = phase_q + 1'b1;
               if (phase_q == PH_LAST) begin
                  held_d = tgt_q;
                  if (src_avail) begin
                     seg_start = 1'b1;
                  end else begin
                     state_d = ST_STARVE;
                     set_ur  = 1'b1;
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end

      if (seg_start) begin
         tgt_d   = src;
         phase_d = '0;
`ifdef DSM_LINEAR_INTERP_EN
         diff_d  = (DIN_W+1)'(src) - (DIN_W+1)'(held_d);
`else
         diff_d  = '0;
         acc_d   = {src, {OSR_LOG2{1'b0}}};
`endif
      end

      // Starting a segment either drains the slot or bypasses it.
      if (seg_start) begin
         pend_vld_d = 1'b0;
      end else if (accept) begin
         pend_d     = s_data;
         pend_vld_d = 1'b1;
      end

      underrun_d = set_ur | (underrun_q & ~clr_underrun);
      xout_d     = acc_ext <<< (SHIFT - OSR_LOG2);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         pend_q     <= '0;
         pend_vld_q <= 1'b0;
         tgt_q      <= '0;
         held_q     <= '0;
         diff_q     <= '0;
         acc_q      <= '0;
         phase_q    <= '0;
         underrun_q <= 1'b0;
         xout_q     <= '0;
      end else begin
         state_q    <= state_d;
         pend_q     <= pend_d;
         pend_vld_q <= pend_vld_d;
         tgt_q      <= tgt_d;
         held_q     <= held_d;
         diff_q     <= diff_d;
         acc_q      <= acc_d;
         phase_q    <= phase_d;
         underrun_q <= underrun_d;
         xout_q     <= xout_d;
      end
   end

   assign s_ready  = ~pend_vld_q;
   assign xout     = xout_q;
   assign underrun = underrun_q;

endmodule
